// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory arbiter: FSM state encoding, access
//   size codes, the per-beat address increment and a helper that turns a
//   requested size/beat count into the number of beats left after beat 0.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  localparam logic [1:0]  SIZE_WORD = 2'b00;
  localparam logic [1:0]  SIZE_HALF = 2'b01;
  localparam logic [1:0]  SIZE_BYTE = 2'b10;
  localparam logic [31:0] ADDR_INC  = 32'd4;

  // Beats still owed after beat 0 has issued. Only word accesses burst;
  // every other size code (including the unused 11) is a single beat, and
  // a word burst length of 0 is treated as 1.
  function automatic logic [3:0] burst_remaining(input logic [1:0] mode,
                                                 input logic [3:0] beats);
    logic [3:0] rem;
    rem = 4'd0;
    if (mode == SIZE_WORD && beats != 4'd0) begin
      rem = beats - 4'd1;
    end
    return rem;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the fetch port, the data-access port and the memory port of
//   the arbiter.
//   slave  : arbiter side (takes i_* signals, drives o_* signals)
//   master : environment side (drives i_* signals, observes o_* signals)
interface mem_arbiter_if;
  // instruction fetch
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        i_if_flush;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic        o_stall_if;
  // data access
  logic        i_dm_req;
  logic        i_dm_we;
  logic [31:0] i_dm_addr;
  logic [1:0]  i_dm_mode;
  logic [3:0]  i_dm_beats;
  logic [31:0] i_dm_wdata;
  logic        o_dm_wack;
  logic        o_dm_rvalid;
  logic        o_dm_busy;
  logic        o_dm_done;
  // shared read data
  logic [31:0] o_rdata;
  // memory port
  logic        o_mem_en;
  logic        o_mem_we;
  logic [1:0]  o_mem_mode;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_if_flush,
    output o_if_gnt, o_if_rvalid, o_stall_if,
    input  i_dm_req, i_dm_we, i_dm_addr, i_dm_mode, i_dm_beats, i_dm_wdata,
    output o_dm_wack, o_dm_rvalid, o_dm_busy, o_dm_done,
    output o_rdata,
    output o_mem_en, o_mem_we, o_mem_mode, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr, i_if_flush,
    input  o_if_gnt, o_if_rvalid, o_stall_if,
    output i_dm_req, i_dm_we, i_dm_addr, i_dm_mode, i_dm_beats, i_dm_wdata,
    input  o_dm_wack, o_dm_rvalid, o_dm_busy, o_dm_done,
    input  o_rdata,
    input  o_mem_en, o_mem_we, o_mem_mode, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_burst_cnt.sv
// burst_cnt
//   Remaining-beat down-counter paired with the next-beat address register.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     load            beat 0 issuing: capture load_addr+4 and load_remaining
//     load_addr       address of beat 0
//     load_remaining  beats still owed after beat 0
//     step            a burst beat issued: advance address, count down
//     addr            address of the next beat to issue
//     remaining       beats still owed
module burst_cnt
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic [3:0]  load_remaining,
  input  logic        step,
  output logic [31:0] addr,
  output logic [3:0]  remaining
);

  logic [31:0] addr_reg;
  logic [3:0]  remaining_reg;

  // Address arithmetic is plain 32-bit, so a burst crossing the top of the
  // address space wraps to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg      <= 32'd0;
      remaining_reg <= 4'd0;
    end else if (load) begin
      addr_reg      <= load_addr + ADDR_INC;
      remaining_reg <= load_remaining;
    end else if (step) begin
      addr_reg      <= addr_reg + ADDR_INC;
      remaining_reg <= remaining_reg - 4'd1;
    end
  end

  assign addr      = addr_reg;
  assign remaining = remaining_reg;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates a single memory port between an instruction-fetch port and
//   a data-access port. Data wins over fetch and a data burst runs to
//   completion uninterrupted. Reads return one cycle after issue on the
//   shared o_rdata bus.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-low reset
//     bus  mem_arbiter_if.slave: fetch port, data port, memory port
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t  state_reg, state_next;
  logic        we_reg;
  logic [1:0]  mode_reg;
  logic [31:0] last_addr_reg;
  logic        if_rvalid_reg;
  logic        dm_rvalid_reg;
  logic        done_reg;
  logic        busy_reg;

  logic        issue_dm, issue_if, last_beat;
  logic        cnt_load, cnt_step;
  logic [3:0]  load_remaining;
  logic [31:0] cnt_addr;
  logic [3:0]  cnt_remaining;
  logic [31:0] addr_c;
  logic        we_c;
  logic [1:0]  mode_c;
  logic        mem_en;

  assign load_remaining = burst_remaining(bus.i_dm_mode, bus.i_dm_beats);

  burst_cnt u_burst_cnt (
    .clk            (clk),
    .rst            (rst),
    .load           (cnt_load),
    .load_addr      (bus.i_dm_addr),
    .load_remaining (load_remaining),
    .step           (cnt_step),
    .addr           (cnt_addr),
    .remaining      (cnt_remaining)
  );

  always_comb begin
    state_next = state_reg;
    issue_dm   = 1'b0;
    issue_if   = 1'b0;
    last_beat  = 1'b0;
    cnt_load   = 1'b0;
    cnt_step   = 1'b0;
    addr_c     = last_addr_reg;
    we_c       = 1'b0;
    mode_c     = SIZE_WORD;
    case (state_reg)
      ST_IDLE: begin
        // A data request arriving while the previous access is still
        // finishing (busy through its done cycle) is dropped; it still
        // blocks fetch for that cycle because data has priority.
        if (bus.i_dm_req && !busy_reg) begin
          issue_dm = 1'b1;
          cnt_load = 1'b1;
          addr_c   = bus.i_dm_addr;
          we_c     = bus.i_dm_we;
          mode_c   = bus.i_dm_mode;
          if (load_remaining != 4'd0) begin
            state_next = ST_BURST;
          end else begin
            last_beat = 1'b1;
          end
        end else if (bus.i_if_req && !bus.i_dm_req) begin
          issue_if = 1'b1;
          addr_c   = bus.i_if_addr;
        end
      end
      ST_BURST: begin
        issue_dm = 1'b1;
        cnt_step = 1'b1;
        addr_c   = cnt_addr;
        we_c     = we_reg;
        mode_c   = mode_reg;
        if (cnt_remaining <= 4'd1) begin
          last_beat  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      we_reg        <= 1'b0;
      mode_reg      <= SIZE_WORD;
      last_addr_reg <= 32'd0;
      if_rvalid_reg <= 1'b0;
      dm_rvalid_reg <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      if (cnt_load) begin
        we_reg   <= bus.i_dm_we;
        mode_reg <= bus.i_dm_mode;
      end
      if (mem_en) begin
        last_addr_reg <= addr_c;
      end
      // A flush in the grant cycle kills the fetch data due next cycle.
      if_rvalid_reg <= issue_if && !bus.i_if_flush;
      dm_rvalid_reg <= issue_dm && !we_c;
      done_reg      <= last_beat;
      if (cnt_load) begin
        busy_reg <= 1'b1;
      end else if (done_reg) begin
        busy_reg <= 1'b0;
      end
    end
  end

  // Combinational outputs are qualified with rst so that every output is
  // 0 the moment reset asserts, regardless of input activity.
  assign mem_en          = rst && (issue_dm || issue_if);
  assign bus.o_mem_en    = mem_en;
  assign bus.o_mem_we    = mem_en && we_c;
  assign bus.o_mem_mode  = mem_en ? mode_c : SIZE_WORD;
  assign bus.o_mem_addr  = mem_en ? addr_c : last_addr_reg;
  assign bus.o_mem_wdata = (mem_en && we_c) ? bus.i_dm_wdata : 32'd0;
  assign bus.o_dm_wack   = mem_en && we_c;

  assign bus.o_if_gnt    = rst && issue_if;
  assign bus.o_stall_if  = rst && bus.i_if_req && !issue_if;

  assign bus.o_if_rvalid = if_rvalid_reg;
  assign bus.o_dm_rvalid = dm_rvalid_reg;
  assign bus.o_rdata     = (if_rvalid_reg || dm_rvalid_reg) ? bus.i_mem_rdata : 32'd0;
  assign bus.o_dm_done   = done_reg;
  assign bus.o_dm_busy   = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed testbench for mem_arbiter. A small memory model returns
//   mv(addr) one cycle after each read issue. Inputs change 1 time unit
//   after the rising edge; outputs are sampled 3 units after the edge.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mv(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Memory model: registered read, one cycle after enable with we=0.
  always @(posedge clk) begin
    if (bus.o_mem_en && !bus.o_mem_we) bus.i_mem_rdata <= mv(bus.o_mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_if_req   = 1'b0;
    bus.i_if_addr  = 32'd0;
    bus.i_if_flush = 1'b0;
    bus.i_dm_req   = 1'b0;
    bus.i_dm_we    = 1'b0;
    bus.i_dm_addr  = 32'd0;
    bus.i_dm_mode  = 2'b00;
    bus.i_dm_beats = 4'd0;
    bus.i_dm_wdata = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0040;
    bus.i_dm_req  = 1'b1;
    bus.i_dm_we   = 1'b1;
    bus.i_dm_addr = 32'h0000_0080;
    #2;
    $display("txn reset: requests held during reset");
    total++; if (bus.o_if_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%0h exp=0", bus.o_if_gnt); end
    total++; if (bus.o_mem_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%0h exp=0", bus.o_mem_en); end
    total++; if (bus.o_stall_if !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", bus.o_stall_if); end
    total++; if (bus.o_dm_wack !== 1'b0) begin bad++; $display("FAIL rst_wack got=%0h exp=0", bus.o_dm_wack); end
    total++; if (bus.o_mem_addr !== 32'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.o_mem_addr); end
    total++; if (bus.o_dm_busy !== 1'b0 || bus.o_dm_done !== 1'b0) begin bad++; $display("FAIL rst_busy_done got=%0h%0h exp=00", bus.o_dm_busy, bus.o_dm_done); end
    total++; if (bus.o_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.o_rdata); end
    tick();
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_single_fetch();
    tick();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0100;
    #2;
    $display("txn fetch addr=00000100");
    total++; if (bus.o_if_gnt !== 1'b1) begin bad++; $display("FAIL fetch_gnt got=%0h exp=1", bus.o_if_gnt); end
    total++; if (bus.o_mem_en !== 1'b1) begin bad++; $display("FAIL fetch_en got=%0h exp=1", bus.o_mem_en); end
    total++; if (bus.o_mem_addr !== 32'h100) begin bad++; $display("FAIL fetch_addr got=%h exp=00000100", bus.o_mem_addr); end
    total++; if (bus.o_mem_we !== 1'b0 || bus.o_mem_mode !== 2'b00) begin bad++; $display("FAIL fetch_we_mode got=%0h/%0h exp=0/0", bus.o_mem_we, bus.o_mem_mode); end
    total++; if (bus.o_stall_if !== 1'b0) begin bad++; $display("FAIL fetch_stall got=%0h exp=0", bus.o_stall_if); end
    tick();
    bus.i_if_req = 1'b0;
    #2;
    total++; if (bus.o_if_rvalid !== 1'b1) begin bad++; $display("FAIL fetch_rvalid got=%0h exp=1", bus.o_if_rvalid); end
    total++; if (bus.o_rdata !== mv(32'h100)) begin bad++; $display("FAIL fetch_rdata got=%h exp=%h", bus.o_rdata, mv(32'h100)); end
    total++; if (bus.o_dm_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_dm_rvalid got=%0h exp=0", bus.o_dm_rvalid); end
    total++; if (bus.o_mem_en !== 1'b0 || bus.o_mem_addr !== 32'h100) begin bad++; $display("FAIL idle_hold got=%0h/%h exp=0/00000100", bus.o_mem_en, bus.o_mem_addr); end
  endtask

  task automatic test_burst_load();
    logic [31:0] exp_addr;
    tick();
    bus.i_dm_req   = 1'b1;
    bus.i_dm_we    = 1'b0;
    bus.i_dm_addr  = 32'h0000_0200;
    bus.i_dm_mode  = 2'b00;
    bus.i_dm_beats = 4'd4;
    bus.i_if_req   = 1'b1;
    bus.i_if_addr  = 32'h0000_0300;
    #2;
    $display("txn load4 addr=00000200 with fetch pending");
    total++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_addr !== 32'h200) begin bad++; $display("FAIL ld_beat0 got=%0h/%h exp=1/00000200", bus.o_mem_en, bus.o_mem_addr); end
    total++; if (bus.o_if_gnt !== 1'b0 || bus.o_stall_if !== 1'b1) begin bad++; $display("FAIL ld_stall0 got=gnt%0h stall%0h exp=gnt0 stall1", bus.o_if_gnt, bus.o_stall_if); end
    total++; if (bus.o_dm_busy !== 1'b0) begin bad++; $display("FAIL ld_busy0 got=%0h exp=0", bus.o_dm_busy); end
    for (int k = 1; k < 4; k++) begin
      tick();
      bus.i_dm_req = 1'b0;
      #2;
      exp_addr = 32'h200 + 32'(4 * k);
      total++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_addr !== exp_addr || bus.o_mem_we !== 1'b0) begin bad++; $display("FAIL ld_beat%0d got=%0h/%h exp=1/%h", k, bus.o_mem_en, bus.o_mem_addr, exp_addr); end
      total++; if (bus.o_stall_if !== 1'b1 || bus.o_if_gnt !== 1'b0) begin bad++; $display("FAIL ld_stall%0d got=%0h exp=1", k, bus.o_stall_if); end
      total++; if (bus.o_dm_rvalid !== 1'b1 || bus.o_rdata !== mv(exp_addr - 32'd4)) begin bad++; $display("FAIL ld_data%0d got=%0h/%h exp=1/%h", k, bus.o_dm_rvalid, bus.o_rdata, mv(exp_addr - 32'd4)); end
      total++; if (bus.o_dm_busy !== 1'b1 || bus.o_dm_done !== 1'b0) begin bad++; $display("FAIL ld_busy%0d got=busy%0h done%0h exp=busy1 done0", k, bus.o_dm_busy, bus.o_dm_done); end
    end
    tick();
    #2;
    total++; if (bus.o_dm_rvalid !== 1'b1 || bus.o_rdata !== mv(32'h20C)) begin bad++; $display("FAIL ld_data4 got=%0h/%h exp=1/%h", bus.o_dm_rvalid, bus.o_rdata, mv(32'h20C)); end
    total++; if (bus.o_dm_done !== 1'b1 || bus.o_dm_busy !== 1'b1) begin bad++; $display("FAIL ld_done got=done%0h busy%0h exp=done1 busy1", bus.o_dm_done, bus.o_dm_busy); end
    total++; if (bus.o_if_gnt !== 1'b1 || bus.o_mem_addr !== 32'h300 || bus.o_stall_if !== 1'b0) begin bad++; $display("FAIL ld_fetch_gnt got=%0h/%h exp=1/00000300", bus.o_if_gnt, bus.o_mem_addr); end
    tick();
    bus.i_if_req = 1'b0;
    #2;
    total++; if (bus.o_if_rvalid !== 1'b1 || bus.o_rdata !== mv(32'h300)) begin bad++; $display("FAIL ld_fetch_data got=%0h/%h exp=1/%h", bus.o_if_rvalid, bus.o_rdata, mv(32'h300)); end
    total++; if (bus.o_dm_rvalid !== 1'b0 || bus.o_dm_done !== 1'b0 || bus.o_dm_busy !== 1'b0) begin bad++; $display("FAIL ld_after got=rv%0h done%0h busy%0h exp=000", bus.o_dm_rvalid, bus.o_dm_done, bus.o_dm_busy); end
  endtask

  task automatic test_byte_store();
    tick();
    bus.i_dm_req   = 1'b1;
    bus.i_dm_we    = 1'b1;
    bus.i_dm_addr  = 32'h0000_0403;
    bus.i_dm_mode  = 2'b10;
    bus.i_dm_beats = 4'd5;
    bus.i_dm_wdata = 32'h1122_3344;
    #2;
    $display("txn store byte addr=00000403 beats=5");
    total++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 32'h403) begin bad++; $display("FAIL sb_issue got=%0h/%0h/%h exp=1/1/00000403", bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr); end
    total++; if (bus.o_mem_mode !== 2'b10) begin bad++; $display("FAIL sb_mode got=%0h exp=2", bus.o_mem_mode); end
    total++; if (bus.o_dm_wack !== 1'b1 || bus.o_mem_wdata !== 32'h1122_3344) begin bad++; $display("FAIL sb_wack got=%0h/%h exp=1/11223344", bus.o_dm_wack, bus.o_mem_wdata); end
    tick();
    bus.i_dm_addr = 32'h0000_0500;   // request while busy must be ignored
    #2;
    total++; if (bus.o_mem_en !== 1'b0 || bus.o_dm_wack !== 1'b0) begin bad++; $display("FAIL sb_single got=en%0h wack%0h exp=en0 wack0", bus.o_mem_en, bus.o_dm_wack); end
    total++; if (bus.o_dm_done !== 1'b1 || bus.o_dm_busy !== 1'b1) begin bad++; $display("FAIL sb_done got=done%0h busy%0h exp=done1 busy1", bus.o_dm_done, bus.o_dm_busy); end
    total++; if (bus.o_dm_rvalid !== 1'b0) begin bad++; $display("FAIL sb_rvalid got=%0h exp=0", bus.o_dm_rvalid); end
    tick();
    bus.i_dm_req = 1'b0;
    #2;
    total++; if (bus.o_dm_done !== 1'b0 || bus.o_dm_busy !== 1'b0 || bus.o_mem_en !== 1'b0) begin bad++; $display("FAIL sb_after got=done%0h busy%0h en%0h exp=000", bus.o_dm_done, bus.o_dm_busy, bus.o_mem_en); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    tick();
    bus.i_dm_req   = 1'b1;
    bus.i_dm_we    = 1'b1;
    bus.i_dm_addr  = 32'hFFFF_FFFC;
    bus.i_dm_mode  = 2'b00;
    bus.i_dm_beats = 4'd2;
    bus.i_dm_wdata = 32'hAAAA_0001;
    #2;
    $display("txn store2 addr=fffffffc wrap");
    total++; if (bus.o_mem_addr !== 32'hFFFF_FFFC || bus.o_dm_wack !== 1'b1) begin bad++; $display("FAIL wrap_b0 got=%h/%0h exp=fffffffc/1", bus.o_mem_addr, bus.o_dm_wack); end
    tick();
    bus.i_dm_req   = 1'b0;
    bus.i_dm_wdata = 32'hAAAA_0002;
    #2;
    total++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_b1 got=%0h/%h exp=1/00000000", bus.o_mem_en, bus.o_mem_addr); end
    total++; if (bus.o_dm_wack !== 1'b1 || bus.o_mem_wdata !== 32'hAAAA_0002) begin bad++; $display("FAIL wrap_wdata got=%0h/%h exp=1/aaaa0002", bus.o_dm_wack, bus.o_mem_wdata); end
    tick();
    bus.i_dm_wdata = 32'd0;
    #2;
    total++; if (bus.o_dm_done !== 1'b1 || bus.o_mem_en !== 1'b0) begin bad++; $display("FAIL wrap_done got=done%0h en%0h exp=done1 en0", bus.o_dm_done, bus.o_mem_en); end
    idle_inputs();
  endtask

  task automatic test_flush();
    tick();
    bus.i_if_req   = 1'b1;
    bus.i_if_addr  = 32'h0000_0500;
    bus.i_if_flush = 1'b1;
    #2;
    $display("txn fetch addr=00000500 flushed");
    total++; if (bus.o_if_gnt !== 1'b1) begin bad++; $display("FAIL flush_gnt got=%0h exp=1", bus.o_if_gnt); end
    tick();
    bus.i_if_addr  = 32'h0000_0504;
    bus.i_if_flush = 1'b0;
    #2;
    $display("txn fetch addr=00000504");
    total++; if (bus.o_if_rvalid !== 1'b0) begin bad++; $display("FAIL flush_suppress got=%0h exp=0", bus.o_if_rvalid); end
    total++; if (bus.o_if_gnt !== 1'b1 || bus.o_mem_addr !== 32'h504) begin bad++; $display("FAIL flush_next_gnt got=%0h/%h exp=1/00000504", bus.o_if_gnt, bus.o_mem_addr); end
    tick();
    bus.i_if_req = 1'b0;
    #2;
    total++; if (bus.o_if_rvalid !== 1'b1 || bus.o_rdata !== mv(32'h504)) begin bad++; $display("FAIL flush_next_data got=%0h/%h exp=1/%h", bus.o_if_rvalid, bus.o_rdata, mv(32'h504)); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    tick();
    bus.i_dm_req   = 1'b1;
    bus.i_dm_we    = 1'b1;
    bus.i_dm_addr  = 32'h0000_0600;
    bus.i_dm_mode  = 2'b00;
    bus.i_dm_beats = 4'd4;
    bus.i_dm_wdata = 32'h5555_0000;
    #2;
    $display("txn store4 addr=00000600 reset at beat 2");
    total++; if (bus.o_mem_addr !== 32'h600 || bus.o_dm_wack !== 1'b1) begin bad++; $display("FAIL rmb_b0 got=%h/%0h exp=00000600/1", bus.o_mem_addr, bus.o_dm_wack); end
    tick();
    bus.i_dm_req = 1'b0;
    #2;
    total++; if (bus.o_mem_addr !== 32'h604) begin bad++; $display("FAIL rmb_b1 got=%h exp=00000604", bus.o_mem_addr); end
    tick();
    rst = 1'b0;
    #2;
    total++; if (bus.o_mem_en !== 1'b0 || bus.o_dm_wack !== 1'b0 || bus.o_mem_we !== 1'b0) begin bad++; $display("FAIL rmb_en got=en%0h wack%0h we%0h exp=000", bus.o_mem_en, bus.o_dm_wack, bus.o_mem_we); end
    total++; if (bus.o_mem_addr !== 32'd0 || bus.o_mem_wdata !== 32'd0) begin bad++; $display("FAIL rmb_bus got=%h/%h exp=0/0", bus.o_mem_addr, bus.o_mem_wdata); end
    total++; if (bus.o_dm_busy !== 1'b0) begin bad++; $display("FAIL rmb_busy got=%0h exp=0", bus.o_dm_busy); end
    tick();
    rst = 1'b1;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      #2;
      total++; if (bus.o_dm_done !== 1'b0 || bus.o_dm_rvalid !== 1'b0 || bus.o_dm_busy !== 1'b0 || bus.o_mem_en !== 1'b0) begin bad++; $display("FAIL rmb_quiet%0d got=done%0h rv%0h busy%0h en%0h exp=0000", k, bus.o_dm_done, bus.o_dm_rvalid, bus.o_dm_busy, bus.o_mem_en); end
    end
    tick();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0700;
    #2;
    $display("txn fetch addr=00000700 after reset");
    total++; if (bus.o_if_gnt !== 1'b1 || bus.o_mem_addr !== 32'h700) begin bad++; $display("FAIL rmb_fetch_gnt got=%0h/%h exp=1/00000700", bus.o_if_gnt, bus.o_mem_addr); end
    tick();
    bus.i_if_req = 1'b0;
    #2;
    total++; if (bus.o_if_rvalid !== 1'b1 || bus.o_rdata !== mv(32'h700)) begin bad++; $display("FAIL rmb_fetch_data got=%0h/%h exp=1/%h", bus.o_if_rvalid, bus.o_rdata, mv(32'h700)); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_fetch();
    test_burst_load();
    test_byte_store();
    test_wrap();
    test_flush();
    test_reset_mid_burst();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
